// File: rtl/udp_pkg.sv
// Shared definitions for the UDP payload packer.
//   UDP_HDR_BYTES / IPUDP_HDR_BYTES : header sizes added to the payload length
//   state_t                         : packer FSM states
//   lane_t, LANE_FIRST, LANE_LAST   : byte-lane indices inside a 32-bit word
//   lane_insert()                   : places a byte into its big-endian lane
package udp_pkg;

  localparam int UDP_HDR_BYTES   = 8;
  localparam int IPUDP_HDR_BYTES = 28;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FILL    = 3'd1,
    ST_FLUSH   = 3'd2,
    ST_PAD     = 3'd3,
    ST_COMMIT  = 3'd4,
    ST_WAIT_TX = 3'd5
  } state_t;

  typedef logic [1:0] lane_t;

  localparam lane_t LANE_FIRST = 2'd0;
  localparam lane_t LANE_LAST  = 2'd3;

  // Lane 0 is the most significant byte (network byte order).
  function automatic logic [31:0] lane_insert(input logic [31:0] word,
                                              input lane_t       lane,
                                              input logic [7:0]  b);
    logic [31:0] w;
    w = word;
    case (lane)
      2'd0:    w[31:24] = b;
      2'd1:    w[23:16] = b;
      2'd2:    w[15:8]  = b;
      default: w[7:0]   = b;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/udp_word_fifo.sv
// Synchronous 32-bit word FIFO, depth 2^AW.
//   clk, rst_n : clock, synchronous active-low reset
//   wr_en      : write strobe (ignored when full)
//   wr_data    : write data
//   rd_en      : read strobe (ignored when empty)
//   rd_data    : registered read data, holds its value between reads
//   empty/full : occupancy flags
//   count      : words currently stored (0 .. 2^AW)
module udp_word_fifo #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count
);

  logic [DW-1:0] mem [2**AW];
  logic [AW:0]   wr_ptr_q;
  logic [AW:0]   rd_ptr_q;
  logic [DW-1:0] rd_data_q;
  logic          do_wr;
  logic          do_rd;

  // Pointers carry one extra bit so full and empty are distinguishable.
  assign count   = wr_ptr_q - rd_ptr_q;
  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(2**AW));
  assign do_wr   = wr_en & ~full;
  assign do_rd   = rd_en & ~empty;
  assign rd_data = rd_data_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rd_data_q <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) begin
        rd_data_q <= mem[rd_ptr_q[AW-1:0]];
        rd_ptr_q  <= rd_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/udp_payload_packer.sv
// Packs a delimited byte stream into big-endian 32-bit words, buffers them,
// pads short frames and publishes UDP/IP length fields to the transmitter.
//   clk, clr       : clock, synchronous active-low reset
//   din/din_valid/din_last/din_ready : byte stream input with handshake
//   read_udp_fifo  : word read strobe from the transmitter
//   datain         : registered FIFO read data
//   fifo_empty     : FIFO holds no words
//   rx_finish      : one-cycle pulse, a complete frame is buffered
//   tx_finish      : transmitter done, re-opens the input
//   mydata_num     : UDP length (8 + 4*words)
//   total_len      : IP total length (28 + 4*words)
//   truncated      : with rx_finish, frame closed by size or idle timeout
module udp_payload_packer
  import udp_pkg::*;
#(
  parameter int AW        = 8,
  parameter int MAX_BYTES = 1024,
  parameter int MIN_WORDS = 5,
  parameter int TIMEOUT   = 4096
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [7:0]  din,
  input  logic        din_valid,
  input  logic        din_last,
  output logic        din_ready,
  input  logic        read_udp_fifo,
  output logic [31:0] datain,
  output logic        fifo_empty,
  output logic        rx_finish,
  input  logic        tx_finish,
  output logic [15:0] mydata_num,
  output logic [15:0] total_len,
  output logic        truncated
);

  localparam int          BCW       = $clog2(MAX_BYTES + 1);
  localparam int          TW        = $clog2(TIMEOUT + 1);
  localparam logic [AW:0] WORDS_MAX = (AW+1)'(2**AW);
  localparam logic [AW:0] WORDS_MIN = (AW+1)'(MIN_WORDS);

  state_t         state_q, state_d;
  lane_t          lane_q, lane_d;
  logic [31:0]    word_q, word_d;
  logic [BCW-1:0] bcnt_q, bcnt_d;
  logic [TW-1:0]  idle_q, idle_d;
  logic [AW:0]    wcnt_q, wcnt_d;
  logic           wr_req_q, wr_req_d;
  logic [31:0]    wr_data_q, wr_data_d;
  logic           trunc_q, trunc_d;
  logic           rx_finish_q;
  logic           truncated_q;
  logic [15:0]    mydata_q;
  logic [15:0]    total_q;
  logic           accept;
  logic           close;
  logic           close_trunc;
  logic [31:0]    packed_word;
  logic           fifo_full;
  logic [AW:0]    fifo_count;
  logic           unused_fifo;

  function automatic logic [AW:0] wcnt_inc(input logic [AW:0] c);
    return (c == WORDS_MAX) ? c : c + 1'b1;
  endfunction

  // Gated by clr so the input reads not-ready while reset is held.
  assign din_ready   = clr & ((state_q == ST_IDLE) | (state_q == ST_FILL));
  assign accept      = din_valid & din_ready;
  assign packed_word = lane_insert((lane_q == LANE_FIRST) ? '0 : word_q, lane_q, din);

  assign rx_finish   = rx_finish_q;
  assign truncated   = truncated_q;
  assign mydata_num  = mydata_q;
  assign total_len   = total_q;
  assign unused_fifo = ^{fifo_full, fifo_count};

  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    word_d      = word_q;
    bcnt_d      = bcnt_q;
    idle_d      = idle_q;
    wcnt_d      = wcnt_q;
    wr_req_d    = 1'b0;
    wr_data_d   = wr_data_q;
    trunc_d     = trunc_q;
    close       = 1'b0;
    close_trunc = 1'b0;
    case (state_q)
      ST_IDLE, ST_FILL: begin
        if (accept) begin
          bcnt_d = bcnt_q + 1'b1;
          idle_d = '0;
          if (lane_q == LANE_LAST) begin
            wr_req_d  = 1'b1;
            wr_data_d = packed_word;
            wcnt_d    = wcnt_inc(wcnt_q);
            word_d    = '0;
            lane_d    = LANE_FIRST;
          end else begin
            word_d = packed_word;
            lane_d = lane_q + 1'b1;
          end
          if (din_last) begin
            close = 1'b1;
          end else if (bcnt_d == BCW'(MAX_BYTES)) begin
            close       = 1'b1;
            close_trunc = 1'b1;
          end else begin
            state_d = ST_FILL;
          end
        end else if (state_q == ST_FILL) begin
          if (idle_q == TW'(TIMEOUT - 1)) begin
            close       = 1'b1;
            close_trunc = 1'b1;
          end else begin
            idle_d = idle_q + 1'b1;
          end
        end
        // Skip FLUSH/PAD entirely when there is nothing left to write.
        if (close) begin
          trunc_d = close_trunc;
          if (lane_d != LANE_FIRST)   state_d = ST_FLUSH;
          else if (wcnt_d < WORDS_MIN) state_d = ST_PAD;
          else                        state_d = ST_COMMIT;
        end
      end
      ST_FLUSH: begin
        wr_req_d  = 1'b1;
        wr_data_d = word_q;
        wcnt_d    = wcnt_inc(wcnt_q);
        word_d    = '0;
        lane_d    = LANE_FIRST;
        state_d   = (wcnt_d < WORDS_MIN) ? ST_PAD : ST_COMMIT;
      end
      ST_PAD: begin
        wr_req_d  = 1'b1;
        wr_data_d = '0;
        wcnt_d    = wcnt_inc(wcnt_q);
        state_d   = (wcnt_d < WORDS_MIN) ? ST_PAD : ST_COMMIT;
      end
      ST_COMMIT: begin
        state_d = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        if (tx_finish) begin
          state_d = ST_IDLE;
          bcnt_d  = '0;
          idle_d  = '0;
          wcnt_d  = '0;
          lane_d  = LANE_FIRST;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q     <= ST_IDLE;
      lane_q      <= LANE_FIRST;
      word_q      <= '0;
      bcnt_q      <= '0;
      idle_q      <= '0;
      wcnt_q      <= '0;
      wr_req_q    <= 1'b0;
      wr_data_q   <= '0;
      trunc_q     <= 1'b0;
      rx_finish_q <= 1'b0;
      truncated_q <= 1'b0;
      mydata_q    <= '0;
      total_q     <= '0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      word_q      <= word_d;
      bcnt_q      <= bcnt_d;
      idle_q      <= idle_d;
      wcnt_q      <= wcnt_d;
      wr_req_q    <= wr_req_d;
      wr_data_q   <= wr_data_d;
      trunc_q     <= trunc_d;
      // COMMIT coincides with the final FIFO write, so the pulse lands one cycle later.
      rx_finish_q <= (state_q == ST_COMMIT);
      truncated_q <= (state_q == ST_COMMIT) & trunc_q;
      if (state_q == ST_COMMIT) begin
        mydata_q <= 16'(UDP_HDR_BYTES)   + 16'({wcnt_q, 2'b00});
        total_q  <= 16'(IPUDP_HDR_BYTES) + 16'({wcnt_q, 2'b00});
      end
    end
  end

  udp_word_fifo #(
    .AW (AW),
    .DW (32)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (clr),
    .wr_en   (wr_req_q),
    .wr_data (wr_data_q),
    .rd_en   (read_udp_fifo),
    .rd_data (datain),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count)
  );

endmodule

// File: tb/tb_udp_payload_packer.sv
module tb_udp_payload_packer;

  logic        clk = 1'b0;
  logic        clr;
  logic [7:0]  din;
  logic        din_valid;
  logic        din_last;
  logic        din_ready;
  logic        read_udp_fifo;
  logic [31:0] datain;
  logic        fifo_empty;
  logic        rx_finish;
  logic        tx_finish;
  logic [15:0] mydata_num;
  logic [15:0] total_len;
  logic        truncated;

  int tests_run    = 0;
  int tests_failed = 0;
  int rx_count     = 0;

  always #5 clk = ~clk;

  udp_payload_packer #(
    .AW        (8),
    .MAX_BYTES (1024),
    .MIN_WORDS (5),
    .TIMEOUT   (4096)
  ) dut (
    .clk           (clk),
    .clr           (clr),
    .din           (din),
    .din_valid     (din_valid),
    .din_last      (din_last),
    .din_ready     (din_ready),
    .read_udp_fifo (read_udp_fifo),
    .datain        (datain),
    .fifo_empty    (fifo_empty),
    .rx_finish     (rx_finish),
    .tx_finish     (tx_finish),
    .mydata_num    (mydata_num),
    .total_len     (total_len),
    .truncated     (truncated)
  );

  always @(negedge clk) if (rx_finish === 1'b1) rx_count++;

  function automatic logic [7:0] bval(input int i);
    return 8'(i) ^ 8'(i >> 8);
  endfunction

  // All stimulus tasks start and end just after a falling edge.
  task automatic send_byte(input logic [7:0] b, input logic last);
    int n = 0;
    din = b; din_valid = 1'b1; din_last = last;
    while (din_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    if (din_ready !== 1'b1) begin
      tests_run++; tests_failed++;
      $display("FAIL send_byte_ready: got %b required 1", din_ready);
    end
    @(posedge clk); @(negedge clk);
    din_valid = 1'b0; din_last = 1'b0;
  endtask

  task automatic read_word(output logic [31:0] w);
    read_udp_fifo = 1'b1;
    @(posedge clk); @(negedge clk);
    read_udp_fifo = 1'b0;
    w = datain;
  endtask

  task automatic wait_rx(input int limit, output int n, output bit got, output logic tr);
    n = 0; got = 1'b0; tr = 1'b0;
    while (n < limit && !got) begin
      @(negedge clk); n++;
      if (rx_finish === 1'b1) begin got = 1'b1; tr = truncated; end
    end
  endtask

  task automatic finish_tx();
    tx_finish = 1'b1;
    @(posedge clk); @(negedge clk);
    tx_finish = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (din_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_din_ready: got %b required 0", din_ready); end
    tests_run++;
    if ({datain, fifo_empty, rx_finish, truncated, mydata_num, total_len} !== {32'h0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0}) begin
      tests_failed++;
      $display("FAIL reset_outputs: got datain=%h empty=%b rx=%b tr=%b udp=%0d ip=%0d required 00000000 1 0 0 0 0",
               datain, fifo_empty, rx_finish, truncated, mydata_num, total_len);
    end
    clr = 1'b1;
    @(negedge clk);
    tests_run++;
    if (din_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_release_ready: got %b required 1", din_ready); end
  endtask

  task automatic test_short_frame();
    logic [31:0] exp [5];
    logic [31:0] w;
    int n, rx0; bit got; logic tr;
    exp = '{32'h01020304, 32'h05060000, 32'h0, 32'h0, 32'h0};
    rx0 = rx_count;
    for (int i = 1; i <= 6; i++) send_byte(8'(i), i == 6);
    tests_run++;
    if (din_ready !== 1'b0) begin tests_failed++; $display("FAIL short_ready_low: got %b required 0", din_ready); end
    wait_rx(50, n, got, tr);
    tests_run++;
    if (!got) begin tests_failed++; $display("FAIL short_rx: got no rx_finish required pulse within 50 cycles"); end
    tests_run++;
    if (tr !== 1'b0) begin tests_failed++; $display("FAIL short_truncated: got %b required 0", tr); end
    tests_run++;
    if (mydata_num !== 16'd28) begin tests_failed++; $display("FAIL short_udp_len: got %0d required 28", mydata_num); end
    tests_run++;
    if (total_len !== 16'd48) begin tests_failed++; $display("FAIL short_ip_len: got %0d required 48", total_len); end
    @(negedge clk);
    tests_run++;
    if (rx_finish !== 1'b0) begin tests_failed++; $display("FAIL short_rx_pulse: got %b required 0", rx_finish); end
    for (int k = 0; k < 5; k++) begin
      read_word(w);
      tests_run++;
      if (w !== exp[k]) begin tests_failed++; $display("FAIL short_word%0d: got %h required %h", k, w, exp[k]); end
    end
    tests_run++;
    if (fifo_empty !== 1'b1) begin tests_failed++; $display("FAIL short_empty: got %b required 1", fifo_empty); end
    tests_run++;
    if (rx_count !== rx0 + 1) begin tests_failed++; $display("FAIL short_rx_count: got %0d required %0d", rx_count, rx0 + 1); end
    finish_tx();
    tests_run++;
    if (din_ready !== 1'b1) begin tests_failed++; $display("FAIL short_tx_ready: got %b required 1", din_ready); end
  endtask

  task automatic test_forty_bytes();
    logic [31:0] w, e;
    int n, bad; bit got; logic tr;
    for (int i = 1; i <= 40; i++) send_byte(8'(i), i == 40);
    wait_rx(50, n, got, tr);
    tests_run++;
    if (!got || tr !== 1'b0) begin tests_failed++; $display("FAIL forty_rx: got rx=%b tr=%b required rx=1 tr=0", got, tr); end
    tests_run++;
    if (mydata_num !== 16'd48 || total_len !== 16'd68) begin
      tests_failed++; $display("FAIL forty_lens: got %0d/%0d required 48/68", mydata_num, total_len);
    end
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      read_word(w);
      e = {8'(4*k+1), 8'(4*k+2), 8'(4*k+3), 8'(4*k+4)};
      if (w !== e) begin
        if (bad == 0) $display("FAIL forty_word%0d: got %h required %h", k, w, e);
        bad++;
      end
    end
    tests_run++;
    if (bad != 0) tests_failed++;
    tests_run++;
    if (fifo_empty !== 1'b1) begin tests_failed++; $display("FAIL forty_empty: got %b required 1", fifo_empty); end
    read_word(w);
    tests_run++;
    if (w !== 32'h25262728) begin tests_failed++; $display("FAIL forty_empty_read_hold: got %h required 25262728", w); end
    finish_tx();
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] w;
    int n, rx0; bit got; logic tr;
    rx0 = rx_count;
    for (int i = 0; i < 10; i++) send_byte(8'(8'h30 + i), 1'b0);
    clr = 1'b0;
    @(negedge clk); @(negedge clk);
    tests_run++;
    if ({din_ready, datain, fifo_empty, rx_finish, truncated, mydata_num, total_len} !==
        {1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0}) begin
      tests_failed++;
      $display("FAIL midreset_outputs: got rdy=%b datain=%h empty=%b rx=%b tr=%b udp=%0d ip=%0d required 0 00000000 1 0 0 0 0",
               din_ready, datain, fifo_empty, rx_finish, truncated, mydata_num, total_len);
    end
    clr = 1'b1;
    repeat (20) @(negedge clk);
    tests_run++;
    if (rx_count !== rx0 || fifo_empty !== 1'b1) begin
      tests_failed++; $display("FAIL midreset_no_rx: got rx_count=%0d empty=%b required %0d 1", rx_count, fifo_empty, rx0);
    end
    send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0); send_byte(8'h33, 1'b0); send_byte(8'h44, 1'b1);
    wait_rx(50, n, got, tr);
    tests_run++;
    if (!got || mydata_num !== 16'd28) begin tests_failed++; $display("FAIL midreset_frame: got rx=%b udp=%0d required 1 28", got, mydata_num); end
    read_word(w);
    tests_run++;
    if (w !== 32'h11223344) begin tests_failed++; $display("FAIL midreset_word0: got %h required 11223344", w); end
    for (int k = 1; k < 5; k++) begin
      read_word(w);
      tests_run++;
      if (w !== 32'h0) begin tests_failed++; $display("FAIL midreset_pad%0d: got %h required 00000000", k, w); end
    end
    tests_run++;
    if (fifo_empty !== 1'b1) begin tests_failed++; $display("FAIL midreset_empty: got %b required 1", fifo_empty); end
    finish_tx();
  endtask

  task automatic test_timeout();
    logic [31:0] w;
    int n; bit got; logic tr;
    send_byte(8'hAA, 1'b0); send_byte(8'hBB, 1'b0); send_byte(8'hCC, 1'b0);
    wait_rx(4300, n, got, tr);
    tests_run++;
    if (!got || n < 4100 || n > 4104) begin
      tests_failed++; $display("FAIL timeout_latency: got rx=%b after %0d cycles required rx=1 after 4100..4104", got, n);
    end
    tests_run++;
    if (tr !== 1'b1) begin tests_failed++; $display("FAIL timeout_truncated: got %b required 1", tr); end
    tests_run++;
    if (mydata_num !== 16'd28 || total_len !== 16'd48) begin
      tests_failed++; $display("FAIL timeout_lens: got %0d/%0d required 28/48", mydata_num, total_len);
    end
    read_word(w);
    tests_run++;
    if (w !== 32'hAABBCC00) begin tests_failed++; $display("FAIL timeout_word0: got %h required aabbcc00", w); end
    for (int k = 1; k < 5; k++) begin
      read_word(w);
      tests_run++;
      if (w !== 32'h0) begin tests_failed++; $display("FAIL timeout_pad%0d: got %h required 00000000", k, w); end
    end
    tests_run++;
    if (fifo_empty !== 1'b1) begin tests_failed++; $display("FAIL timeout_empty: got %b required 1", fifo_empty); end
    finish_tx();
    tests_run++;
    if (din_ready !== 1'b1) begin tests_failed++; $display("FAIL timeout_tx_ready: got %b required 1", din_ready); end
  endtask

  task automatic test_max_bytes();
    logic [31:0] w, e;
    int n, bad, rx0; bit got; logic tr;
    rx0 = rx_count;
    for (int i = 0; i < 1024; i++) send_byte(bval(i), 1'b0);
    tests_run++;
    if (din_ready !== 1'b0) begin tests_failed++; $display("FAIL max_ready_low: got %b required 0", din_ready); end
    wait_rx(20, n, got, tr);
    tests_run++;
    if (!got || tr !== 1'b1) begin tests_failed++; $display("FAIL max_rx: got rx=%b tr=%b required 1 1", got, tr); end
    tests_run++;
    if (mydata_num !== 16'd1032 || total_len !== 16'd1052) begin
      tests_failed++; $display("FAIL max_lens: got %0d/%0d required 1032/1052", mydata_num, total_len);
    end
    // Byte 1024 is offered while blocked and must not be consumed yet.
    din = bval(1024); din_valid = 1'b1; din_last = 1'b0;
    bad = 0;
    for (int k = 0; k < 256; k++) begin
      read_word(w);
      e = {bval(4*k), bval(4*k+1), bval(4*k+2), bval(4*k+3)};
      if (w !== e) begin
        if (bad == 0) $display("FAIL max_word%0d: got %h required %h", k, w, e);
        bad++;
      end
    end
    tests_run++;
    if (bad != 0) tests_failed++;
    tests_run++;
    if (fifo_empty !== 1'b1 || din_ready !== 1'b0) begin
      tests_failed++; $display("FAIL max_drained: got empty=%b rdy=%b required 1 0", fifo_empty, din_ready);
    end
    finish_tx();
    tests_run++;
    if (din_ready !== 1'b1) begin tests_failed++; $display("FAIL max_tx_ready: got %b required 1", din_ready); end
    @(posedge clk); @(negedge clk);
    din_valid = 1'b0;
    for (int i = 1025; i < 1100; i++) send_byte(bval(i), 1'b0);
    wait_rx(5000, n, got, tr);
    tests_run++;
    if (!got || tr !== 1'b1) begin tests_failed++; $display("FAIL max_tail_rx: got rx=%b tr=%b required 1 1", got, tr); end
    tests_run++;
    if (mydata_num !== 16'd84 || total_len !== 16'd104) begin
      tests_failed++; $display("FAIL max_tail_lens: got %0d/%0d required 84/104", mydata_num, total_len);
    end
    bad = 0;
    for (int k = 0; k < 19; k++) begin
      read_word(w);
      e = {bval(1024+4*k), bval(1025+4*k), bval(1026+4*k), bval(1027+4*k)};
      if (w !== e) begin
        if (bad == 0) $display("FAIL max_tail_word%0d: got %h required %h", k, w, e);
        bad++;
      end
    end
    tests_run++;
    if (bad != 0) tests_failed++;
    tests_run++;
    if (fifo_empty !== 1'b1 || rx_count !== rx0 + 2) begin
      tests_failed++; $display("FAIL max_tail_end: got empty=%b rx_count=%0d required 1 %0d", fifo_empty, rx_count, rx0 + 2);
    end
    finish_tx();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clr = 1'b0; din = '0; din_valid = 1'b0; din_last = 1'b0;
    read_udp_fifo = 1'b0; tx_finish = 1'b0;
    @(negedge clk);
    test_reset();
    test_short_frame();
    test_forty_bytes();
    test_reset_mid_frame();
    test_timeout();
    test_max_bytes();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/udp_payload_packer.md
# udp_payload_packer

Upstream stage of the UDP/IP MII transmitter. Accepts a byte stream with frame delimiters, packs bytes big-endian into 32-bit words, buffers them in a word FIFO, pads short frames to the Ethernet minimum, and computes the UDP and IP length fields. When a whole frame is buffered it raises `rx_finish` to the transmitter, then blocks new input until the transmitter returns `tx_finish`.

## Interface
- `AW`, 8: FIFO address width; depth is 2^AW words (256 words = 1024 bytes).
- `MAX_BYTES`, 1024: payload bytes at which a frame is force-closed; must be ≤ 4·2^AW.
- `MIN_WORDS`, 5: minimum payload words; 20 bytes covers the 18-byte UDP minimum.
- `TIMEOUT`, 4096: idle cycles inside an open frame before it is force-closed.

- `clk` in 1: single clock.
- `clr` in 1: reset, synchronous, active-low.
- `din` in 8: payload byte.
- `din_valid` in 1: `din` valid.
- `din_last` in 1: qualifies the final byte of the frame.
- `din_ready` out 1: byte accepted when `din_valid & din_ready`.
- `read_udp_fifo` in 1: FIFO read strobe from the transmitter.
- `datain` out 32: FIFO read data, registered.
- `fifo_empty` out 1: FIFO holds no words.
- `rx_finish` out 1: one-cycle pulse; a complete frame is buffered.
- `tx_finish` in 1: transmitter finished the frame.
- `mydata_num` out 16: UDP length = 8 + 4·words.
- `total_len` out 16: IP total length = 28 + 4·words.
- `truncated` out 1: one-cycle pulse with `rx_finish` when the frame was closed by `MAX_BYTES` or `TIMEOUT` rather than `din_last`.

## Operation
- States: IDLE, FILL, FLUSH, PAD, COMMIT, WAIT_TX.
- IDLE: `din_ready`=1. The first accepted byte goes to FILL.
- FILL: bytes pack into a shift register. Byte 0 goes to [31:24], then [23:16], [15:8], [7:0]. Each full word is written to the FIFO.
- Frame close triggers, in priority order:
  - `din_last` on an accepted byte;
  - byte count reaches `MAX_BYTES` (`truncated`);
  - idle counter reaches `TIMEOUT` (`truncated`). The counter resets on every accepted byte.
- On close, FLUSH writes a partial word if one exists, zero-filling the low bytes.
- PAD writes zero words until the word count equals `MIN_WORDS`.
- COMMIT:
  - `rx_finish`=1 for one cycle;
  - `mydata_num` and `total_len` are updated and then held stable until the next COMMIT;
  - go to WAIT_TX.
- WAIT_TX: `din_ready`=0. `tx_finish`=1 returns the block to IDLE.
- Word count is 9 bits, saturating at 2^AW. Length arithmetic is 16-bit and never overflows, since the maximum is 28 + 1024.
- FIFO:
  - A read of an empty FIFO is ignored; `datain` holds its value.
  - A write is never issued when the FIFO is full, because `MAX_BYTES` bounds a frame to the depth and a frame is drained before the next one starts.
  - Simultaneous read and write are legal.

## Timing
- Reset values:
  - `din_ready`=0 during reset, 1 in the first cycle after reset;
  - `datain`=0, `fifo_empty`=1, `rx_finish`=0, `truncated`=0;
  - `mydata_num`=0, `total_len`=0;
  - FIFO pointers 0, state IDLE.
- The FIFO write occurs 1 cycle after the 4th byte of a word is accepted.
- FLUSH takes 1 cycle, or 0 cycles if no partial word exists. PAD takes 1 cycle per pad word.
- `rx_finish` rises the cycle after the last FIFO write of the frame.
- `din_ready` falls the cycle after the closing byte is accepted and stays low until the cycle after `tx_finish`.
- `datain` is valid 1 cycle after `read_udp_fifo`. `fifo_empty` updates the cycle after the read.
- `tx_finish` outside WAIT_TX is ignored.
- A `din_valid` byte presented while `din_ready`=0 is not consumed; the source holds it.
- Reset mid-frame discards buffered data. No `rx_finish` is issued.

## Structure
- Package `udp_pkg`:
  - `UDP_HDR_BYTES`=8, `IPUDP_HDR_BYTES`=28;
  - state enum;
  - byte-lane constants.
- Sub-module `udp_word_fifo`:
  - synchronous FIFO with parameter `AW`;
  - ports: registered read data, `empty`, `full`, word count.
- Top level contains the packer, FSM, timeout counter and length registers.

## Test plan
- 6 bytes 01..06, `din_last` on 06:
  - FIFO words are 01020304, 05060000, then 3 zero words;
  - `mydata_num`=28, `total_len`=48, one `rx_finish`, `truncated`=0.
- 40 bytes with `din_last`:
  - 10 words, no padding;
  - `mydata_num`=48, `total_len`=68.
- 1100 bytes with no `din_last`:
  - frame closes after byte 1024, `truncated`=1;
  - `mydata_num`=1032, `total_len`=1052;
  - `din_ready`=0 until `tx_finish`, then byte 1025 starts the next frame.
- 3 bytes, then `din_valid` low for 4096 cycles:
  - timeout close, `truncated`=1, 5 words;
  - first word AABBCC00 for input AA BB CC.
- Transmitter-model drain:
  - assert `read_udp_fifo` per word, check `datain` one cycle later;
  - `fifo_empty`=1 after the last word;
  - pulse `tx_finish`, then `din_ready`=1 on the next cycle.
- Reset mid-frame after 10 bytes:
  - `fifo_empty`=1 and all outputs at reset values;
  - no `rx_finish`;
  - a following 4-byte frame produces exactly 5 words.
